code_serializer: RTL and testbench

//   Downstream stage of the TX button encoder. Takes the 8-bit symbol code and

---
 rtl/code_serializer.sv | 214 +++++++++++++++++++++
 tb/tb_code_serializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/code_serializer.sv
// code_serializer: shifts a symbol code out MSB-first as an on-off-keyed line, each
// frame followed by an idle gap. Define SER_CARRIER_EN to gate data bits with a carrier.
module code_serializer #(
    parameter int WIDTH        = 8,
    parameter int BIT_CYCLES   = 50000,
    parameter int GAP_BITS     = 8,
    parameter int CARRIER_HALF = 658
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] code,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int MAXB = (WIDTH > GAP_BITS) ? WIDTH : GAP_BITS;
    localparam int IW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    localparam logic [CW-1:0] CNT_LAST     = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [IW-1:0] IDX_ONE      = IW'(1);
    localparam logic [IW-1:0] IDX_DATA_TOP = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_GAP_TOP  = IW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam bit            HAS_GAP      = (GAP_BITS > 0);

    // Reject configurations the shifter and counters cannot represent.
    if (WIDTH < 2 || BIT_CYCLES < 1 || GAP_BITS < 0 || CARRIER_HALF < 1) begin : g_param_check
        $error("code_serializer: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic [IW-1:0]    idx_r, idx_nx_s;
    logic [WIDTH-1:0] shreg_r, shreg_nx_s;
    logic             bit_end_s, idx_zero_s, code_nz_s;
    logic             tx_nx_s, busy_nx_s, done_nx_s;

    assign bit_end_s  = (cnt_r == CNT_LAST);
    assign idx_zero_s = (idx_r == {IW{1'b0}});
    assign code_nz_s  = (code != {WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: a frame ends on the last cycle of the last bit period.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (code_nz_s) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_end_s && idx_zero_s) begin
                    if (HAS_GAP) begin
                        state_nx_s = ST_GAP;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (bit_end_s && idx_zero_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath next values: bit-period counter, bit/gap index and shift register.
    always_comb begin
        cnt_nx_s   = cnt_r;
        idx_nx_s   = idx_r;
        shreg_nx_s = shreg_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {CW{1'b0}};
                if (code_nz_s) begin
                    shreg_nx_s = code;
                    idx_nx_s   = IDX_DATA_TOP;
                end else begin
                    shreg_nx_s = {WIDTH{1'b0}};
                    idx_nx_s   = {IW{1'b0}};
                end
            end
            ST_SHIFT: begin
                if (bit_end_s) begin
                    cnt_nx_s   = {CW{1'b0}};
                    shreg_nx_s = {shreg_r[WIDTH-2:0], 1'b0};
                    if (idx_zero_s) begin
                        idx_nx_s = HAS_GAP ? IDX_GAP_TOP : {IW{1'b0}};
                    end else begin
                        idx_nx_s = idx_r - IDX_ONE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (bit_end_s) begin
                    cnt_nx_s = {CW{1'b0}};
                    if (idx_zero_s) begin
                        idx_nx_s = {IW{1'b0}};
                    end else begin
                        idx_nx_s = idx_r - IDX_ONE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nx_s   = {CW{1'b0}};
                idx_nx_s   = {IW{1'b0}};
                shreg_nx_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
            shreg_r <= {WIDTH{1'b0}};
        end else begin
            cnt_r   <= cnt_nx_s;
            idx_r   <= idx_nx_s;
            shreg_r <= shreg_nx_s;
        end
    end

`ifdef SER_CARRIER_EN
    localparam int             CHW      = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CHW-1:0] CAR_LAST = CHW'(CARRIER_HALF - 1);
    localparam logic [CHW-1:0] CAR_ONE  = CHW'(1);

    logic [CHW-1:0] car_cnt_r, car_cnt_nx_s;
    logic           car_r, car_nx_s;

    // Carrier next value; preloaded high in IDLE so a frame starts on a high half-period.
    always_comb begin
        car_cnt_nx_s = car_cnt_r;
        car_nx_s     = car_r;
        if (state_r == ST_IDLE) begin
            car_cnt_nx_s = {CHW{1'b0}};
            car_nx_s     = 1'b1;
        end else if (car_cnt_r == CAR_LAST) begin
            car_cnt_nx_s = {CHW{1'b0}};
            car_nx_s     = ~car_r;
        end else begin
            car_cnt_nx_s = car_cnt_r + CAR_ONE;
            car_nx_s     = car_r;
        end
    end

    // Carrier registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_cnt_r <= {CHW{1'b0}};
            car_r     <= 1'b0;
        end else begin
            car_cnt_r <= car_cnt_nx_s;
            car_r     <= car_nx_s;
        end
    end
`endif

    // Output decode from the upcoming state so the registered outputs align with it.
    always_comb begin
        busy_nx_s = (state_nx_s != ST_IDLE);
        done_nx_s = (state_r != ST_IDLE) && (state_nx_s == ST_IDLE);
`ifdef SER_CARRIER_EN
        tx_nx_s   = (state_nx_s == ST_SHIFT) && shreg_nx_s[WIDTH-1] && car_nx_s;
`else
        tx_nx_s   = (state_nx_s == ST_SHIFT) && shreg_nx_s[WIDTH-1];
`endif
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_out     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_out     <= tx_nx_s;
            busy       <= busy_nx_s;
            frame_done <= done_nx_s;
        end
    end

endmodule

// File: tb/tb_code_serializer.sv
// tb_code_serializer: directed table, hand-written corner sequences and randomized
// traffic checked against a frame-offset reference model.
module tb_code_serializer;

    localparam int W  = 8;
    localparam int BC = 4;
    localparam int GB = 2;
    localparam int CH = 1;
    localparam int N  = (W + GB) * BC;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] code = 8'h00;
    logic         tx_out, busy, frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a frame is described only by its latched code and the
    // number of cycles since it started.
    bit           m_act  = 1'b0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_code = 8'h00;
    int           m_off  = 0;

    typedef struct {
        logic [7:0] c0;
        logic [7:0] c1;
        int         chg;
        logic [7:0] bits;
        int         busy_end;
        int         done_at;
    } vec_t;

    vec_t vecs[5];

    code_serializer #(
        .WIDTH(W), .BIT_CYCLES(BC), .GAP_BITS(GB), .CARRIER_HALF(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .code(code),
        .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic carrier_at(int off);
`ifdef SER_CARRIER_EN
        return (((off - 1) / CH) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2:0] model_out();
        logic t;
        t = 1'b0;
        if (m_act && m_off <= W * BC)
            t = m_code[W - 1 - (m_off - 1) / BC] & carrier_at(m_off);
        return {t, m_act, m_done};
    endfunction

    function automatic logic [2:0] frame_exp(logic [7:0] bits, int off, int busy_end, int done_at);
        logic t;
        t = 1'b0;
        if (off >= 1 && off <= W * BC)
            t = bits[W - 1 - (off - 1) / BC] & carrier_at(off);
        return {t, (off >= 1 && off <= busy_end), (off == done_at)};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_act  = 1'b0;
            m_done = 1'b0;
        end else if (m_act) begin
            m_off++;
            if (m_off == N + 1) begin
                m_act  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (code != 8'h00) begin
                m_act  = 1'b1;
                m_code = code;
                m_off  = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] exp);
        total++;
        if ({tx_out, busy, frame_done} !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got(tx,busy,done)=%b want=%b",
                     nm, cyc, {tx_out, busy, frame_done}, exp);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA0, 8'h00, 1,  8'hA0, 40, 41};
        vecs[1] = '{8'h80, 8'hAA, 10, 8'h80, 40, 41};
        vecs[2] = '{8'h01, 8'h00, 1,  8'h01, 40, 41};
        vecs[3] = '{8'hFF, 8'h00, 1,  8'hFF, 40, 41};
        vecs[4] = '{8'h5A, 8'hC3, 3,  8'h5A, 40, 41};

        // Reset held with a non-zero code, then release into IDLE with code=0.
        rst_n = 1'b0;
        code  = 8'hAA;
        #2;
        chk("reset_async_entry", 3'b000);
        repeat (5) begin
            tick();
            chk("reset_hold", 3'b000);
        end
        code  = 8'h00;
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_after_reset", 3'b000);
        end

        // Single frames, including code changes mid-frame that must be ignored.
        for (int i = 0; i < 5; i++) begin
            code = vecs[i].c0;
            for (int k = 1; k <= 50; k++) begin
                tick();
                chk($sformatf("vec%0d_k%0d", i, k),
                    frame_exp(vecs[i].bits, k, vecs[i].busy_end, vecs[i].done_at));
                code = (k < vecs[i].chg) ? vecs[i].c0 : ((k < 30) ? vecs[i].c1 : 8'h00);
            end
        end

        // Held code: frames repeat with a period of N+1 clocks.
        code = 8'hAA;
        for (int k = 1; k <= 90; k++) begin
            tick();
            chk($sformatf("repeat_k%0d", k),
                frame_exp(8'hAA, ((k - 1) % (N + 1)) + 1, N, N + 1));
        end
        code = 8'h00;
        repeat (50) tick();
        chk("repeat_drained", 3'b000);

        // Asynchronous reset in the middle of a frame.
        code = 8'hFF;
        tick();
        code = 8'h00;
        repeat (12) tick();
        chk("pre_reset_frame", {carrier_at(13), 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_frame_async_reset", 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("post_reset_idle", 3'b000);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 8)
                code = 8'($urandom);
            else if (r >= 5)
                code = 8'h00;
            else
                code = code;
            tick();
            chk("random", model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
